// File: rtl/alu_control_unit_if.sv
// Instruction handshake and ALU operand/result bus between an instruction
// source, the ALU control unit and the 32-bit ALU.
interface alu_control_unit_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_z;
  logic        alu_n;

  modport master (
    output instr, instr_valid, alu_result, alu_carry, alu_z, alu_n,
    input  instr_ready, alu_op, alu_a, alu_b
  );

  modport slave (
    input  instr, instr_valid, alu_result, alu_carry, alu_z, alu_n,
    output instr_ready, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_control_unit.sv
// Multi-cycle decode/execute/writeback controller in front of a 32-bit ALU,
// with an 8x32 register file (r0 hard-wired to zero).
module alu_control_unit (
  input  logic                   clk,
  input  logic                   rst,
  alu_control_unit_if.slave      bus,
  output logic                   done,
  output logic                   illegal,
  output logic                   flag_c,
  output logic                   flag_z,
  output logic                   flag_n,
  input  logic [2:0]             dbg_addr,
  output logic [31:0]            dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b010000, 6'b010001,
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b110000, 6'b110001, 6'b110010: is_legal = 1'b1;
      default:                         is_legal = 1'b0;
    endcase
  endfunction

  state_t      state_r, next_s;
  logic [31:0] instr_r;
  logic [31:0] regs_r [8];
  logic [31:0] result_r;
  logic [5:0]  alu_op_r;
  logic [31:0] alu_a_r, alu_b_r;
  logic        done_r, illegal_r;
  logic        flag_c_r, flag_z_r, flag_n_r;
  logic        accept_s;
  logic [31:0] rs1_val_s, rs2_val_s, op_b_s;

  wire [5:0]  opcode = instr_r[31:26];
  wire [2:0]  rd     = instr_r[25:23];
  wire [2:0]  rs1    = instr_r[22:20];
  wire [2:0]  rs2    = instr_r[19:17];

  assign bus.instr_ready = (state_r == IDLE) & ~rst;
  assign accept_s        = bus.instr_valid & bus.instr_ready;

  assign bus.alu_op = alu_op_r;
  assign bus.alu_a  = alu_a_r;
  assign bus.alu_b  = alu_b_r;
  assign done       = done_r;
  assign illegal    = illegal_r;
  assign flag_c     = flag_c_r;
  assign flag_z     = flag_z_r;
  assign flag_n     = flag_n_r;
  assign dbg_data   = (dbg_addr == 3'd0) ? 32'd0 : regs_r[dbg_addr];

  // Operand fetch from the register file for the latched instruction
  always_comb begin
    rs1_val_s = (rs1 == 3'd0) ? 32'd0 : regs_r[rs1];
    rs2_val_s = (rs2 == 3'd0) ? 32'd0 : regs_r[rs2];
    if (instr_r[16]) begin
      op_b_s = {16'd0, instr_r[15:0]};
    end else begin
      op_b_s = rs2_val_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_s = DECODE;
        end else begin
          next_s = IDLE;
        end
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          next_s = EXECUTE;
        end else begin
          next_s = IDLE;
        end
      end
      EXECUTE:   next_s = WRITEBACK;
      WRITEBACK: next_s = IDLE;
      default:   next_s = IDLE;
    endcase
  end

  // Instruction latch, ALU drive registers, result capture, flags and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r   <= 32'd0;
      alu_op_r  <= 6'd0;
      alu_a_r   <= 32'd0;
      alu_b_r   <= 32'd0;
      result_r  <= 32'd0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      flag_c_r  <= 1'b0;
      flag_z_r  <= 1'b0;
      flag_n_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        instr_r <= bus.instr;
      end else begin
        instr_r <= instr_r;
      end
      // Legality is known from the incoming word, so the pulse lands in DECODE
      illegal_r <= accept_s & ~is_legal(bus.instr[31:26]);
      done_r    <= (state_r == EXECUTE);
      case (state_r)
        DECODE: begin
          if (is_legal(opcode)) begin
            alu_op_r <= opcode;
            alu_a_r  <= rs1_val_s;
            alu_b_r  <= op_b_s;
          end else begin
            alu_op_r <= 6'd0;
            alu_a_r  <= 32'd0;
            alu_b_r  <= 32'd0;
          end
        end
        EXECUTE: begin
          result_r <= bus.alu_result;
          flag_z_r <= bus.alu_z;
          flag_n_r <= bus.alu_n;
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            flag_c_r <= bus.alu_carry;
          end else begin
            flag_c_r <= flag_c_r;
          end
          alu_op_r <= 6'd0;
          alu_a_r  <= 32'd0;
          alu_b_r  <= 32'd0;
        end
        default: begin
          alu_op_r <= 6'd0;
          alu_a_r  <= 32'd0;
          alu_b_r  <= 32'd0;
        end
      endcase
    end
  end

  // Register file writeback; r0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else begin
      if ((state_r == WRITEBACK) && (rd != 3'd0)) begin
        regs_r[rd] <= result_r;
      end else begin
        regs_r[rd] <= regs_r[rd];
      end
    end
  end

endmodule
